// File: rtl/clint_timer.sv
// Core-local interruptor: free-running 64-bit mtime, per-hart mtimecmp and msip,
// exposed as a single-outstanding-request bus slave with a one-cycle response.
module clint_timer #(
    parameter int unsigned N_HARTS   = 1,
    parameter int unsigned PRESCALE  = 1,
    parameter logic [31:0] BASE_ADDR = 32'h0200_0000
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_bus_DV,
    input  logic [31:0]        i_bus_address,
    input  logic [31:0]        i_bus_data,
    input  logic               i_write_notread,
    input  logic [2:0]         i_bhw,
    output logic [31:0]        o_bus_data,
    output logic               o_bus_DV,
    output logic [N_HARTS-1:0] o_timer_int,
    output logic [N_HARTS-1:0] o_soft_int,
    output logic [63:0]        o_mtime
);

    localparam int unsigned    PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
    localparam logic [15:0]    BASE_HI = BASE_ADDR[31:16];

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic               accept;
    logic               wr_word;

    logic [PS_W-1:0]    ps_q;
    logic               tick;
    logic [63:0]        mtime_q;
    logic [63:0]        mtimecmp_q [N_HARTS];
    logic [N_HARTS-1:0] msip_q;
    logic [N_HARTS-1:0] timer_match;

    logic               bus_dv_q;
    logic [31:0]        bus_data_q;
    logic [N_HARTS-1:0] timer_q;
    logic [N_HARTS-1:0] soft_q;

    logic [15:0]        offset;
    logic               claimed;
    logic               msip_sel;
    logic               cmp_sel;
    logic               mtime_sel;
    logic               hi_word;
    logic [11:0]        msip_idx;
    logic [10:0]        cmp_idx;
    logic [31:0]        rdata;
    logic               unused_addr_bits;

    // Address decode; byte lane bits are don't-care since reads return full words.
    assign offset           = i_bus_address[15:0];
    assign claimed          = (i_bus_address[31:16] == BASE_HI);
    assign msip_sel         = (offset[15:14] == 2'b00);
    assign cmp_sel          = (offset[15:14] == 2'b01);
    assign mtime_sel        = (offset[15:3] == 13'h17FF);
    assign hi_word          = offset[2];
    assign msip_idx         = offset[13:2];
    assign cmp_idx          = offset[13:3];
    assign unused_addr_bits = ^i_bus_address[1:0];

    // Read mux; unmapped and out-of-range hart offsets read as zero.
    always_comb begin
        rdata = 32'd0;
        if (mtime_sel) begin
            rdata = hi_word ? mtime_q[63:32] : mtime_q[31:0];
        end
        for (int h = 0; h < int'(N_HARTS); h++) begin
            if (msip_sel && (msip_idx == 12'(h))) begin
                rdata = {31'd0, msip_q[h]};
            end
            if (cmp_sel && (cmp_idx == 11'(h))) begin
                rdata = hi_word ? mtimecmp_q[h][63:32] : mtimecmp_q[h][31:0];
            end
        end
    end

    // Response FSM state register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: requests are only accepted in IDLE; anything arriving in RESP is dropped.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_bus_DV && claimed) begin
                    accept  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign wr_word = accept && i_write_notread && (i_bhw == 3'b100);
    assign tick    = (ps_q == PS_MAX);

    // Time base; a bus write to one mtime word wins over the increment for that word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ps_q    <= '0;
            mtime_q <= 64'd0;
        end else begin
            ps_q <= tick ? '0 : ps_q + PS_W'(1);
            if (wr_word && mtime_sel && !hi_word) begin
                mtime_q[31:0] <= i_bus_data;
            end else if (wr_word && mtime_sel && hi_word) begin
                mtime_q[63:32] <= i_bus_data;
                if (tick) begin
                    mtime_q[31:0] <= mtime_q[31:0] + 32'd1;
                end
            end else if (tick) begin
                mtime_q <= mtime_q + 64'd1;
            end
        end
    end

    // Per-hart msip and mtimecmp registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            msip_q <= '0;
            for (int h = 0; h < int'(N_HARTS); h++) begin
                mtimecmp_q[h] <= 64'hFFFF_FFFF_FFFF_FFFF;
            end
        end else begin
            for (int h = 0; h < int'(N_HARTS); h++) begin
                if (wr_word && msip_sel && (msip_idx == 12'(h))) begin
                    msip_q[h] <= i_bus_data[0];
                end
                if (wr_word && cmp_sel && (cmp_idx == 11'(h))) begin
                    if (hi_word) begin
                        mtimecmp_q[h][63:32] <= i_bus_data;
                    end else begin
                        mtimecmp_q[h][31:0] <= i_bus_data;
                    end
                end
            end
        end
    end

    always_comb begin
        timer_match = '0;
        for (int h = 0; h < int'(N_HARTS); h++) begin
            timer_match[h] = (mtime_q >= mtimecmp_q[h]);
        end
    end

    // Registered interrupt levels and bus response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            timer_q    <= '0;
            soft_q     <= '0;
            bus_dv_q   <= 1'b0;
            bus_data_q <= 32'd0;
        end else begin
            timer_q    <= timer_match;
            soft_q     <= msip_q;
            bus_dv_q   <= accept;
            bus_data_q <= accept ? rdata : 32'd0;
        end
    end

    assign o_bus_DV    = bus_dv_q;
    assign o_bus_data  = bus_data_q;
    assign o_timer_int = timer_q;
    assign o_soft_int  = soft_q;
    assign o_mtime     = mtime_q;

endmodule

// File: tb/tb_clint_timer.sv
// Directed bench for clint_timer: register-access table plus timing sequences,
// using one instance at PRESCALE=1 and one at PRESCALE=4.
module tb_clint_timer;

    localparam logic [31:0] B    = 32'h0200_0000;
    localparam logic [2:0]  W    = 3'b100;
    localparam logic [2:0]  HALF = 3'b010;
    localparam logic [2:0]  BYTE = 3'b001;

    logic        clk;
    logic        rst;
    logic        dv0;
    logic        dv1;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_we;
    logic [2:0]  bus_bhw;

    logic [31:0] bus_data0;
    logic        bus_dv0;
    logic [1:0]  timer0;
    logic [1:0]  soft0;
    logic [63:0] mtime0;
    logic [31:0] bus_data1;
    logic        bus_dv1;
    logic [1:0]  timer1;
    logic [1:0]  soft1;
    logic [63:0] mtime1;

    int n_tests = 0;
    int n_fail  = 0;

    logic        ack;
    logic [31:0] rd;
    logic [63:0] mt;
    logic [63:0] m0;

    clint_timer #(.N_HARTS(2), .PRESCALE(1), .BASE_ADDR(B)) u_dut0 (
        .i_clk(clk), .i_rst(rst), .i_bus_DV(dv0), .i_bus_address(bus_addr),
        .i_bus_data(bus_wdata), .i_write_notread(bus_we), .i_bhw(bus_bhw),
        .o_bus_data(bus_data0), .o_bus_DV(bus_dv0), .o_timer_int(timer0),
        .o_soft_int(soft0), .o_mtime(mtime0)
    );

    clint_timer #(.N_HARTS(2), .PRESCALE(4), .BASE_ADDR(B)) u_dut1 (
        .i_clk(clk), .i_rst(rst), .i_bus_DV(dv1), .i_bus_address(bus_addr),
        .i_bus_data(bus_wdata), .i_write_notread(bus_we), .i_bhw(bus_bhw),
        .o_bus_data(bus_data1), .o_bus_DV(bus_dv1), .o_timer_int(timer1),
        .o_soft_int(soft1), .o_mtime(mtime1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic [2:0]  bhw;
        logic        exp_ack;
        logic        chk_data;
        logic [31:0] exp_data;
        logic [1:0]  exp_soft;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One bus transaction; returns ack/data/mtime seen in the response cycle.
    task automatic bus(input logic [31:0] addr, input logic [31:0] wd, input logic we,
                       input logic [2:0] sz, input int sel,
                       output logic a, output logic [31:0] d, output logic [63:0] m);
        bus_addr  = addr;
        bus_wdata = wd;
        bus_we    = we;
        bus_bhw   = sz;
        if (sel == 0) dv0 = 1'b1;
        else          dv1 = 1'b1;
        @(posedge clk); #1;
        dv0 = 1'b0;
        dv1 = 1'b0;
        a = (sel == 0) ? bus_dv0 : bus_dv1;
        d = (sel == 0) ? bus_data0 : bus_data1;
        m = (sel == 0) ? mtime0 : mtime1;
        @(posedge clk); #1;
        chk("dv_single_pulse", 64'((sel == 0) ? bus_dv0 : bus_dv1), 64'd0);
        chk("data_zero_idle", 64'((sel == 0) ? bus_data0 : bus_data1), 64'd0);
    endtask

    initial begin
        rst = 1'b1; dv0 = 1'b0; dv1 = 1'b0;
        bus_addr = '0; bus_wdata = '0; bus_we = 1'b0; bus_bhw = W;

        vq.push_back('{B + 32'h4000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00});
        vq.push_back('{B + 32'h400C, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h0000, 32'hFFFF_FFFF, 1'b1, W,    1'b1, 1'b0, 32'h0,         2'b01});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h1,         2'b01});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b1, BYTE, 1'b1, 1'b0, 32'h0,         2'b01});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h1,         2'b01});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b1, W,    1'b1, 1'b0, 32'h0,         2'b00});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h0004, 32'h1,         1'b1, W,    1'b1, 1'b0, 32'h0,         2'b10});
        vq.push_back('{B + 32'h0004, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h1,         2'b10});
        vq.push_back('{B + 32'h0004, 32'h0,         1'b1, W,    1'b1, 1'b0, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4000, 32'h1234_5678, 1'b1, W,    1'b1, 1'b0, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h1234_5678, 2'b00});
        vq.push_back('{B + 32'h0014, 32'h1,         1'b1, W,    1'b1, 1'b0, 32'h0,         2'b00});
        vq.push_back('{B + 32'h0014, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4028, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{32'h0300_0000, 32'h0,        1'b0, W,    1'b0, 1'b1, 32'h0,         2'b00});
        vq.push_back('{32'h0300_0000, 32'h1,        1'b1, W,    1'b0, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h0000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4004, 32'h0,         1'b1, HALF, 1'b1, 1'b0, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4004, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'hFFFF_FFFF, 2'b00});
        vq.push_back('{B + 32'h8000, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h0,         2'b00});
        vq.push_back('{B + 32'h4003, 32'h0,         1'b0, W,    1'b1, 1'b1, 32'h1234_5678, 2'b00});

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_dv", 64'(bus_dv0), 64'd0);
        chk("rst_data", 64'(bus_data0), 64'd0);
        chk("rst_timer", 64'(timer0), 64'd0);
        chk("rst_soft", 64'(soft0), 64'd0);
        chk("rst_mtime0", mtime0, 64'd0);
        chk("rst_mtime1", mtime1, 64'd0);
        rst = 1'b0;

        // mtime read after exactly 10 increments
        repeat (10) @(posedge clk);
        #1;
        bus(B + 32'hBFF8, 32'h0, 1'b0, W, 0, ack, rd, mt);
        chk("mtime_lo_ack", 64'(ack), 64'd1);
        chk("mtime_lo_data", 64'(rd), 64'd10);
        chk("mtime_at_ack", mt, 64'd11);
        chk("prescale4_mtime", mtime1, 64'd3);
        chk("timer_idle", 64'(timer0), 64'd0);
        bus(B + 32'hBFFC, 32'h0, 1'b0, W, 0, ack, rd, mt);
        chk("mtime_hi_data", 64'(rd), 64'd0);

        // Register access table
        foreach (vq[i]) begin
            bus(vq[i].addr, vq[i].wdata, vq[i].we, vq[i].bhw, 0, ack, rd, mt);
            chk($sformatf("vec%0d_ack", i), 64'(ack), 64'(vq[i].exp_ack));
            if (vq[i].chk_data) chk($sformatf("vec%0d_data", i), 64'(rd), 64'(vq[i].exp_data));
            chk($sformatf("vec%0d_soft", i), 64'(soft0), 64'(vq[i].exp_soft));
        end

        // Timer match on hart 1
        bus(B + 32'h4008, 32'hFFFF_FFFF, 1'b1, W, 0, ack, rd, mt);
        bus(B + 32'h400C, 32'h0, 1'b1, W, 0, ack, rd, mt);
        bus(B + 32'hBFF8, 32'h0, 1'b1, W, 0, ack, rd, mt);
        bus(B + 32'h4008, 32'd50, 1'b1, W, 0, ack, rd, mt);
        chk("timer_before_match", 64'(timer0), 64'd0);
        for (int i = 0; i < 200 && mtime0 != 64'd50; i++) begin
            @(posedge clk); #1;
        end
        chk("mtime_reached_50", mtime0, 64'd50);
        chk("timer_at_50", 64'(timer0), 64'd0);
        @(posedge clk); #1;
        chk("timer_rise", 64'(timer0), 64'b10);
        bus(B + 32'h4008, 32'hFFFF_FFFF, 1'b1, W, 0, ack, rd, mt);
        chk("timer_clear", 64'(timer0), 64'd0);

        // Wrap and write priority
        bus(B + 32'hBFFC, 32'hFFFF_FFFF, 1'b1, W, 0, ack, rd, mt);
        chk("mtime_hi_written", 64'(mt[63:32]), 64'hFFFF_FFFF);
        bus(B + 32'hBFF8, 32'hFFFF_FFFE, 1'b1, W, 0, ack, rd, mt);
        chk("mtime_lo_priority", mt, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("mtime_all_ones", mtime0, 64'hFFFF_FFFF_FFFF_FFFF);
        @(posedge clk); #1;
        chk("mtime_wrap", mtime0, 64'd0);

        // Prescale and decode on the PRESCALE=4 instance
        m0 = mtime1;
        repeat (4) @(posedge clk);
        #1;
        chk("ps4_one_tick", mtime1 - m0, 64'd1);
        repeat (8) @(posedge clk);
        #1;
        chk("ps4_three_ticks", mtime1 - m0, 64'd3);
        bus(32'h0300_0000, 32'h0, 1'b0, W, 1, ack, rd, mt);
        chk("ps4_unclaimed_ack", 64'(ack), 64'd0);
        bus(B + 32'h0014, 32'h0, 1'b0, W, 1, ack, rd, mt);
        chk("ps4_msip5_ack", 64'(ack), 64'd1);
        chk("ps4_msip5_data", 64'(rd), 64'd0);

        // Reset during RESP
        bus_addr = B + 32'h4000; bus_we = 1'b0; bus_bhw = W; dv0 = 1'b1;
        @(posedge clk); #1;
        dv0 = 1'b0;
        chk("resp_before_reset", 64'(bus_dv0), 64'd1);
        rst = 1'b1;
        #1;
        chk("resp_aborted_dv", 64'(bus_dv0), 64'd0);
        chk("resp_aborted_data", 64'(bus_data0), 64'd0);
        chk("reset_mtime", mtime0, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_dv_after_reset", 64'(bus_dv0), 64'd0);
        end
        for (int i = 0; i < 4; i++) begin
            bus(B + 32'h4000 + 32'(4 * i), 32'h0, 1'b0, W, 0, ack, rd, mt);
            chk($sformatf("cmp_word%0d_reset", i), {31'd0, ack, rd}, {31'd0, 1'b1, 32'hFFFF_FFFF});
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clint_timer.md
# clint_timer

Memory-mapped core-local interruptor for up to `N_HARTS` harts, parametrised in hart count, tick prescale and base address. It provides:

- a 64-bit free-running `mtime` counter;
- a 64-bit `mtimecmp` register per hart;
- a software-interrupt (`msip`) bit per hart.

It sits on the CPU data bus as a slave and drives the machine timer and software interrupt inputs of each hart's CLINT logic. It supersedes the free-standing single-hart timer.

## Interface
Parameters:
- `N_HARTS`, 1, number of harts served (1..32).
- `PRESCALE`, 1, input clocks per `mtime` increment (≥1).
- `BASE_ADDR`, 32'h0200_0000, base of the 64 KiB register window; bits [15:0] must be 0.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
  - `i_clk`  in  1  clock.
  - `i_rst`  in  1  asynchronous active-high reset.
- Bus request:
  - `i_bus_DV`  in  1  one-cycle request strobe.
  - `i_bus_address`  in  32  byte address.
  - `i_bus_data`  in  32  write data.
  - `i_write_notread`  in  1  1 = write, 0 = read.
  - `i_bhw`  in  3  access size, one-hot: [0] byte, [1] half, [2] word.
- Bus response:
  - `o_bus_data`  out  32  read data, valid while `o_bus_DV` = 1.
  - `o_bus_DV`  out  1  one-cycle response strobe.
- Interrupts and observation:
  - `o_timer_int`  out  N_HARTS  per-hart machine timer interrupt, level.
  - `o_soft_int`  out  N_HARTS  per-hart machine software interrupt, level.
  - `o_mtime`  out  64  current `mtime`, for tracing.

## Operation
Register map, offsets from `BASE_ADDR`, all 32-bit words:
- `0x0000 + 4*h`: `msip[h]`. Bit 0 is read/write; bits [31:1] read 0.
- `0x4000 + 8*h`: `mtimecmp[h]` low word.
- `0x4004 + 8*h`: `mtimecmp[h]` high word.
- `0xBFF8`: `mtime` low word.
- `0xBFFC`: `mtime` high word.

Address decode:
- A request is claimed only when `i_bus_address[31:16] == BASE_ADDR[31:16]`.
- Unclaimed requests get no response (`o_bus_DV` stays 0).
- Claimed offsets that are unmapped, including h ≥ `N_HARTS`, read 0, ignore writes, and are still acknowledged.

Access size and alignment:
- Only word accesses modify state. A claimed write with `i_bhw != 3'b100` is ignored but acknowledged.
- Reads always return the full word. Address bits [1:0] are ignored.

Response FSM: IDLE → RESP → IDLE.
- In IDLE, a claimed `i_bus_DV` latches read data and performs the write on the same clock edge, then moves to RESP.
- RESP asserts `o_bus_DV` for exactly one cycle with `o_bus_data`, then returns to IDLE.
- `i_bus_DV` arriving in RESP is dropped. The master must not issue back-to-back requests.
- `o_bus_data` is 0 whenever `o_bus_DV` = 0.

Time base:
- A prescaler counts 0..PRESCALE-1. `mtime` increments by 1 on the cycle the prescaler wraps.
- With `PRESCALE` = 1, `mtime` increments every cycle.
- `mtime` wraps from 2^64-1 to 0.
- A bus write to either `mtime` word replaces that word on that edge. It takes priority over the increment in the same cycle; no carry into or out of the written word is applied that cycle. The prescaler is not reset by the write.

Interrupt generation:
- `o_timer_int[h]` is registered: it is 1 in the cycle after `mtime >= mtimecmp[h]` (64-bit unsigned) and is re-evaluated every cycle.
- Clearing is done by writing `mtimecmp` greater than `mtime`.
- Writing `mtimecmp` low and high words separately can give a transient match. Software writes all-ones to the low word first; the block does not suppress the transient.
- `o_soft_int[h] = msip[h]` bit 0, registered.

## Timing
Reset values:
- `mtime` = 0; prescaler = 0.
- every `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF; every `msip` = 0.
- `o_bus_DV` = 0, `o_bus_data` = 0, `o_timer_int` = 0, `o_soft_int` = 0.
- FSM in IDLE.

Latencies:
- Read latency: `o_bus_DV` one cycle after `i_bus_DV`. Data is the register value sampled at the request edge; a `mtime` read returns the pre-increment value.
- Write to `msip` → `o_soft_int` changes one cycle after the write edge.
- Write to `mtimecmp` → `o_timer_int` reflects the new compare one cycle after the write edge.

Reset mid-operation:
- Reset asserted during RESP aborts the response; no `o_bus_DV` pulse follows.
- Reset asserted mid-count clears the prescaler and `mtime` immediately.

## Test plan
- Reset, `PRESCALE` = 1, N_HARTS = 2:
  - read `0xBFF8` at cycle 10 → `o_bus_DV` at cycle 11 with data ≈ 10 (exact cycle count checked);
  - `o_timer_int` = 2'b00.
- Timer match:
  - write `mtimecmp[1]` low = 0xFFFF_FFFF, high = 0, then low = 50;
  - when `mtime` reaches 50, `o_timer_int[1]` rises one cycle later, `o_timer_int[0]` stays 0;
  - write `mtimecmp[1]` low = 0xFFFF_FFFF → bit falls next cycle.
- Wrap and priority:
  - write `mtime` high = 0xFFFF_FFFF and low = 0xFFFF_FFFE;
  - after 2 ticks `mtime` = 0;
  - a write to the low word in the same cycle as an increment stores the written value.
- Software interrupt:
  - write `msip[0]` = 0xFFFF_FFFF → `o_soft_int[0]` = 1, read back returns 1;
  - write 0 → clears;
  - a byte-sized write (`i_bhw` = 3'b001) leaves it unchanged but is acknowledged.
- Prescale and decode, `PRESCALE` = 4:
  - `mtime` advances once per 4 clocks;
  - access to 0x0300_0000 gets no `o_bus_DV`;
  - read of `msip[5]` with N_HARTS = 2 returns 0 with ack.
- Reset mid-response:
  - assert `i_rst` in RESP → no `o_bus_DV`;
  - all `mtimecmp` read back 0xFFFF_FFFF after release.
